// File: rtl/core_load_unit.sv
// Load-return unit: issues one or two aligned memory reads per load, then
// extracts, extends and presents the result to write-back for one cycle.
//
// state  | meaning
// IDLE   | ready for a new load request
// ISSUE0 | first aligned read requested on the bus
// WAIT0  | waiting for the first read response
// ISSUE1 | second read requested (load crosses an aligned boundary)
// WAIT1  | waiting for the second read response
// WB     | result, rd and fault presented to write-back
// DRAIN  | flushed; swallowing one outstanding response
module core_load_unit #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int MISALIGN_EN = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [4:0]        i_req_rd,
  input  logic              i_flush,
  output logic              o_mem_valid,
  input  logic              i_mem_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_rvalid,
  input  logic [XLEN-1:0]   i_mem_rdata,
  output logic              o_wb_valid,
  output logic [4:0]        o_wb_rd,
  output logic [XLEN-1:0]   o_wb_data,
  output logic              o_fault
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(XLEN);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE0, S_WAIT0, S_ISSUE1, S_WAIT1, S_WB, S_DRAIN
  } state_t;

  state_t              state_q;
  logic [OFF_W-1:0]    off_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [4:0]          rd_q;
  logic                split_q;
  logic [XLEN-1:0]     beat0_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_valid_q;
  logic                wb_valid_q;
  logic [4:0]          wb_rd_q;
  logic [XLEN-1:0]     wb_data_q;
  logic                fault_q;

  // Size code 11 means doubleword only when the datapath is 64 bits wide.
  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   size_bytes = 4'd1;
      2'b01:   size_bytes = 4'd2;
      2'b10:   size_bytes = 4'd4;
      default: size_bytes = (XLEN == 64) ? 4'd8 : 4'd4;
    endcase
  endfunction

  logic [OFF_W-1:0] off_in;
  logic             split_in;

  assign off_in   = i_req_addr[OFF_W-1:0];
  assign split_in = (5'(off_in) + 5'(size_bytes(i_req_size))) > 5'(NB);

  logic [XLEN-1:0]   beat0_sel;
  logic [XLEN-1:0]   beat1_sel;
  logic [2*XLEN-1:0] raw;
  logic [6:0]        nbits;
  logic [XLEN-1:0]   keep;
  logic [XLEN-1:0]   mask;
  logic              sign;
  logic [XLEN-1:0]   ext_d;

  // On the final beat the live response is either beat 0 (single) or beat 1.
  always_comb begin
    beat0_sel = (state_q == S_WAIT1) ? beat0_q : i_mem_rdata;
    beat1_sel = (state_q == S_WAIT1) ? i_mem_rdata : '0;
    raw       = {beat1_sel, beat0_sel} >> {off_q, 3'b000};
    nbits     = {size_bytes(size_q), 3'b000};
    keep      = raw[XLEN-1:0];
    mask      = (nbits >= 7'(XLEN)) ? '1 : ((XLEN'(1) << nbits) - XLEN'(1));
    sign      = keep[IDX_W'(nbits - 7'd1)];
    ext_d     = (keep & mask) | ((!uns_q && sign) ? ~mask : '0);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      rd_q        <= '0;
      split_q     <= 1'b0;
      beat0_q     <= '0;
      mem_addr_q  <= '0;
      mem_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      fault_q     <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_req_valid) begin
            off_q   <= off_in;
            size_q  <= i_req_size;
            uns_q   <= i_req_unsigned;
            rd_q    <= i_req_rd;
            split_q <= split_in;
            if (split_in && MISALIGN_EN == 0) begin
              state_q    <= S_WB;
              wb_valid_q <= 1'b1;
              fault_q    <= 1'b1;
              wb_data_q  <= '0;
              wb_rd_q    <= i_req_rd;
            end else begin
              state_q     <= S_ISSUE0;
              mem_valid_q <= 1'b1;
              mem_addr_q  <= {i_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            end
          end
        end
        S_ISSUE0, S_ISSUE1: begin
          if (i_flush) begin
            mem_valid_q <= 1'b0;
            state_q     <= i_mem_ready ? S_DRAIN : S_IDLE;
          end else if (i_mem_ready) begin
            mem_valid_q <= 1'b0;
            state_q     <= (state_q == S_ISSUE0) ? S_WAIT0 : S_WAIT1;
          end
        end
        S_WAIT0, S_WAIT1: begin
          if (i_flush) begin
            state_q <= i_mem_rvalid ? S_IDLE : S_DRAIN;
          end else if (i_mem_rvalid) begin
            if (state_q == S_WAIT0 && split_q) begin
              beat0_q     <= i_mem_rdata;
              mem_addr_q  <= mem_addr_q + ADDR_W'(NB);
              mem_valid_q <= 1'b1;
              state_q     <= S_ISSUE1;
            end else begin
              state_q    <= S_WB;
              wb_valid_q <= 1'b1;
              fault_q    <= 1'b0;
              wb_data_q  <= ext_d;
              wb_rd_q    <= rd_q;
            end
          end
        end
        S_WB: state_q <= S_IDLE;
        S_DRAIN: begin
          if (i_mem_rvalid) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready = (state_q == S_IDLE) && i_rst_n;
  assign o_mem_valid = mem_valid_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_wb_valid  = wb_valid_q;
  assign o_wb_rd     = wb_rd_q;
  assign o_wb_data   = wb_data_q;
  assign o_fault     = fault_q;

endmodule

// File: tb/tb_core_load_unit.sv
// Directed bench for core_load_unit: three instances (32-bit split, 32-bit
// faulting, 64-bit) share stimulus; sel picks which one is driven and observed.
module tb_core_load_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_uns = 1'b0;
  logic [4:0]  req_rd = '0;
  logic        flush = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;
  int          sel = 0;

  int n_vec  = 0;
  int n_miss = 0;

  logic        ready32, ready32f, ready64;
  logic        mv32, mv32f, mv64;
  logic [31:0] ma32, ma32f, ma64;
  logic        wv32, wv32f, wv64;
  logic [4:0]  wr32, wr32f, wr64;
  logic [31:0] wd32, wd32f;
  logic [63:0] wd64;
  logic        f32, f32f, f64;

  logic        ready_m, mem_valid_m, wb_valid_m, fault_m;
  logic [31:0] mem_addr_m;
  logic [4:0]  wb_rd_m;
  logic [63:0] wb_data_m;

  always #5 clk = ~clk;

  core_load_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1)) u_l32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid && sel == 0),
    .o_req_ready(ready32), .i_req_addr(req_addr), .i_req_size(req_size),
    .i_req_unsigned(req_uns), .i_req_rd(req_rd), .i_flush(flush),
    .o_mem_valid(mv32), .i_mem_ready(mem_ready), .o_mem_addr(ma32),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata[31:0]),
    .o_wb_valid(wv32), .o_wb_rd(wr32), .o_wb_data(wd32), .o_fault(f32));

  core_load_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(0)) u_l32f (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid && sel == 1),
    .o_req_ready(ready32f), .i_req_addr(req_addr), .i_req_size(req_size),
    .i_req_unsigned(req_uns), .i_req_rd(req_rd), .i_flush(flush),
    .o_mem_valid(mv32f), .i_mem_ready(mem_ready), .o_mem_addr(ma32f),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata[31:0]),
    .o_wb_valid(wv32f), .o_wb_rd(wr32f), .o_wb_data(wd32f), .o_fault(f32f));

  core_load_unit #(.XLEN(64), .ADDR_W(32), .MISALIGN_EN(1)) u_l64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid && sel == 2),
    .o_req_ready(ready64), .i_req_addr(req_addr), .i_req_size(req_size),
    .i_req_unsigned(req_uns), .i_req_rd(req_rd), .i_flush(flush),
    .o_mem_valid(mv64), .i_mem_ready(mem_ready), .o_mem_addr(ma64),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_wb_valid(wv64), .o_wb_rd(wr64), .o_wb_data(wd64), .o_fault(f64));

  always_comb begin
    ready_m = ready64; mem_valid_m = mv64; mem_addr_m = ma64;
    wb_valid_m = wv64; wb_rd_m = wr64; wb_data_m = wd64; fault_m = f64;
    if (sel == 0) begin
      ready_m = ready32; mem_valid_m = mv32; mem_addr_m = ma32;
      wb_valid_m = wv32; wb_rd_m = wr32; wb_data_m = {32'h0, wd32}; fault_m = f32;
    end else if (sel == 1) begin
      ready_m = ready32f; mem_valid_m = mv32f; mem_addr_m = ma32f;
      wb_valid_m = wv32f; wb_rd_m = wr32f; wb_data_m = {32'h0, wd32f}; fault_m = f32f;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one request; returns #1 into the cycle after the accept edge.
  task automatic start(input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [4:0] rd);
    req_addr = addr; req_size = size; req_uns = uns; req_rd = rd;
    req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
  endtask

  // Zero-wait memory: ready in the same cycle as o_mem_valid, rvalid the next.
  task automatic run_load(input string tag, input int s, input logic [31:0] addr,
                          input logic [1:0] size, input logic uns, input logic [4:0] rd,
                          input logic [63:0] b0, input logic [63:0] b1,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input logic [63:0] exp_data, input logic exp_fault,
                          input int exp_lat, input int exp_nreq);
    int nreq = 0;
    int bi = 0;
    bit pend = 1'b0;
    bit got = 1'b0;
    logic [63:0] beats [2];
    beats[0] = b0;
    beats[1] = b1;
    sel = s;
    start(addr, size, uns, rd);
    for (int c = 1; c <= 12 && !got; c++) begin
      mem_ready = 1'b0;
      mem_rvalid = 1'b0;
      if (pend && bi < 2) begin
        mem_rvalid = 1'b1;
        mem_rdata = beats[bi];
        bi++;
        pend = 1'b0;
      end
      if (mem_valid_m) begin
        check({tag, "_addr"}, 64'(mem_addr_m), 64'((nreq == 0) ? a0 : a1));
        nreq++;
        mem_ready = 1'b1;
        pend = 1'b1;
      end
      if (wb_valid_m) begin
        got = 1'b1;
        check({tag, "_lat"}, 64'(c), 64'(exp_lat));
        check({tag, "_data"}, wb_data_m, exp_data);
        check({tag, "_fault"}, 64'(fault_m), 64'(exp_fault));
        check({tag, "_rd"}, 64'(wb_rd_m), 64'(rd));
      end
      tick;
    end
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    if (!got) check({tag, "_timeout"}, 64'd0, 64'd1);
    check({tag, "_nreq"}, 64'(nreq), 64'(exp_nreq));
    check({tag, "_wb_1cyc"}, 64'(wb_valid_m), 64'd0);
    check({tag, "_ready"}, 64'(ready_m), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick;
    tick;
    check("rst_ready", 64'(ready_m), 64'd0);
    check("rst_mem_valid", 64'(mem_valid_m), 64'd0);
    check("rst_mem_addr", 64'(mem_addr_m), 64'd0);
    check("rst_wb_valid", 64'(wb_valid_m), 64'd0);
    check("rst_fault", 64'(fault_m), 64'd0);
    check("rst_wb_rd", 64'(wb_rd_m), 64'd0);
    check("rst_wb_data", wb_data_m, 64'd0);
    rst_n = 1'b1;
    tick;
    check("idle_ready", 64'(ready_m), 64'd1);

    run_load("lb",   0, 32'h1003, 2'b00, 1'b0, 5'd1, 64'h80FF_1234, 64'h0,
             32'h1000, 32'h0, 64'hFFFF_FF80, 1'b0, 3, 1);
    run_load("lbu",  0, 32'h1003, 2'b00, 1'b1, 5'd2, 64'h80FF_1234, 64'h0,
             32'h1000, 32'h0, 64'h0000_0080, 1'b0, 3, 1);
    run_load("lh",   0, 32'h2002, 2'b01, 1'b0, 5'd3, 64'h8001_5555, 64'h0,
             32'h2000, 32'h0, 64'hFFFF_8001, 1'b0, 3, 1);
    run_load("lhu",  0, 32'h2002, 2'b01, 1'b1, 5'd4, 64'h8001_5555, 64'h0,
             32'h2000, 32'h0, 64'h0000_8001, 1'b0, 3, 1);
    run_load("lw_split", 0, 32'h3003, 2'b10, 1'b0, 5'd5, 64'h4433_2211, 64'h8877_6655,
             32'h3000, 32'h3004, 64'h7766_5544, 1'b0, 5, 2);
    run_load("lw_fault", 1, 32'h3003, 2'b10, 1'b0, 5'd6, 64'h4433_2211, 64'h8877_6655,
             32'h0, 32'h0, 64'h0, 1'b1, 1, 0);
    run_load("lb_nofault", 1, 32'h1003, 2'b00, 1'b0, 5'd7, 64'h80FF_1234, 64'h0,
             32'h1000, 32'h0, 64'hFFFF_FF80, 1'b0, 3, 1);
    run_load("ld64", 2, 32'h10, 2'b11, 1'b0, 5'd8, 64'h0123_4567_89AB_CDEF, 64'h0,
             32'h10, 32'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 3, 1);
    run_load("lw64_hi", 2, 32'h14, 2'b10, 1'b0, 5'd9, 64'h0123_4567_89AB_CDEF, 64'h0,
             32'h10, 32'h0, 64'h0000_0000_0123_4567, 1'b0, 3, 1);
    run_load("lw64_lo", 2, 32'h10, 2'b10, 1'b0, 5'd10, 64'h0123_4567_89AB_CDEF, 64'h0,
             32'h10, 32'h0, 64'hFFFF_FFFF_89AB_CDEF, 1'b0, 3, 1);
    run_load("lh64_split", 2, 32'h17, 2'b01, 1'b0, 5'd11, 64'h0123_4567_89AB_CDEF,
             64'hFEDC_BA98_7654_3210, 32'h10, 32'h18, 64'h0000_0000_0000_1001, 1'b0, 5, 2);

    // Flush while waiting for a response that arrives three cycles late.
    sel = 0;
    start(32'h4000, 2'b10, 1'b0, 5'd12);
    check("fl_issue", 64'(mem_valid_m), 64'd1);
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    for (int c = 0; c < 2; c++) begin
      check("fl_busy", 64'(ready_m), 64'd0);
      check("fl_nowb", 64'(wb_valid_m), 64'd0);
      tick;
    end
    mem_rvalid = 1'b1;
    mem_rdata = 64'hDEAD_BEEF;
    check("fl_busy_rv", 64'(ready_m), 64'd0);
    tick;
    mem_rvalid = 1'b0;
    check("fl_ready", 64'(ready_m), 64'd1);
    check("fl_nowb_end", 64'(wb_valid_m), 64'd0);

    // Flush in ISSUE0 without a handshake returns straight to IDLE.
    start(32'h7000, 2'b00, 1'b0, 5'd13);
    check("fli_issue", 64'(mem_valid_m), 64'd1);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    check("fli_ready", 64'(ready_m), 64'd1);
    check("fli_mem_valid", 64'(mem_valid_m), 64'd0);

    // Memory stalls four cycles; request must hold steady.
    start(32'h5001, 2'b00, 1'b0, 5'd14);
    for (int c = 0; c < 4; c++) begin
      check("st_valid", 64'(mem_valid_m), 64'd1);
      check("st_addr", 64'(mem_addr_m), 64'h5000);
      tick;
    end
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 64'h0000_7F00;
    tick;
    mem_rvalid = 1'b0;
    check("st_wb_valid", 64'(wb_valid_m), 64'd1);
    check("st_wb_data", wb_data_m, 64'h7F);
    check("st_wb_rd", 64'(wb_rd_m), 64'd14);
    tick;

    // Reset during WAIT1, then a stray response.
    start(32'h6002, 2'b10, 1'b0, 5'd15);
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 64'h1111_2222;
    tick;
    mem_rvalid = 1'b0;
    check("rs_issue1", 64'(mem_valid_m), 64'd1);
    check("rs_addr1", 64'(mem_addr_m), 64'h6004);
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    rst_n = 1'b0;
    tick;
    check("rs_ready_low", 64'(ready_m), 64'd0);
    check("rs_mem_valid", 64'(mem_valid_m), 64'd0);
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 64'h3333_4444;
    tick;
    mem_rvalid = 1'b0;
    check("rs_nowb", 64'(wb_valid_m), 64'd0);
    check("rs_ready", 64'(ready_m), 64'd1);
    check("rs_wb_data", wb_data_m, 64'd0);
    tick;
    check("rs_nowb2", 64'(wb_valid_m), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/core_load_unit.md
# core_load_unit

Parametrised load-return unit for the core's memory/write-back path. It accepts one load request at a time and issues one or two aligned XLEN-wide memory reads over a valid/ready bus. It extracts and zero- or sign-extends the addressed byte, half, word or doubleword, then presents the result and destination register to write-back for one cycle. Unlike a purely combinational write-back sizer, it handles misaligned loads by splitting them across two memory beats (or faulting), and it supports XLEN=64 and flush.

## Interface
- XLEN, 32, data width; legal values 32 or 64.
- ADDR_W, 32, byte-address width.
- MISALIGN_EN, 1, 1 = split accesses that cross an XLEN/8 boundary; 0 = report a fault instead.

- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_req_valid  in  1  load request valid.
- o_req_ready  out  1  unit idle, so a request can be accepted.
- i_req_addr  in  ADDR_W  byte address.
- i_req_size  in  2  size code: 00 byte, 01 half, 10 word, 11 double (XLEN=64) or word (XLEN=32).
- i_req_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
- i_req_rd  in  5  destination register.
- i_flush  in  1  abort the in-flight load.
- o_mem_valid  out  1  memory read request.
- i_mem_ready  in  1  memory accepts the request.
- o_mem_addr  out  ADDR_W  read address, always aligned to XLEN/8.
- i_mem_rvalid  in  1  read data valid; exactly one per accepted request, returned in order.
- i_mem_rdata  in  XLEN  read data.
- o_wb_valid  out  1  one-cycle write-back strobe.
- o_wb_rd  out  5  destination register.
- o_wb_data  out  XLEN  sized and extended load result.
- o_fault  out  1  misaligned fault; qualified by o_wb_valid.

## Operation
- Let NB = XLEN/8, off = addr mod NB, and bytes = 1, 2, 4 or 8 by size.
- A request is a split when off + bytes > NB.
- The request is captured on the cycle where i_req_valid && o_req_ready. Address, size, unsigned and rd are registered at that point.
- FSM states:
  - IDLE: o_req_ready = 1.
  - ISSUE0: o_mem_valid = 1, o_mem_addr = addr with the low log2(NB) bits cleared.
  - WAIT0: wait for the first response.
  - ISSUE1: o_mem_addr = first-beat address + NB.
  - WAIT1: wait for the second response.
  - WB: o_wb_valid = 1.
  - DRAIN: discard one pending response.
- Transitions:
  - IDLE → ISSUE0 on accept.
  - If the request is a split and MISALIGN_EN=0, IDLE → WB instead, with o_fault=1 and o_wb_data=0. No memory access is made.
  - ISSUE0 → WAIT0 on i_mem_ready.
  - WAIT0 → WB on i_mem_rvalid when the request is not a split; → ISSUE1 when it is.
  - ISSUE1 → WAIT1 on i_mem_ready. WAIT1 → WB on i_mem_rvalid.
  - WB → IDLE unconditionally.
- Datapath:
  - The beat-0 data is registered.
  - The raw value is {beat1, beat0} shifted right by off×8; beat1 is 0 when the request is not a split.
  - The low bytes×8 bits are kept. If signed, they are sign-extended from bit bytes×8−1; otherwise zero-extended to XLEN.
- o_mem_valid and o_mem_addr stay stable while waiting for i_mem_ready.
- Flush (any state other than IDLE and WB):
  - In ISSUE0 or ISSUE1 without i_mem_ready → IDLE.
  - In ISSUE0 or ISSUE1 with i_mem_ready in the same cycle → DRAIN.
  - In WAIT0 or WAIT1 without i_mem_rvalid → DRAIN; with i_mem_rvalid in the same cycle → IDLE.
  - DRAIN → IDLE on i_mem_rvalid. No o_wb_valid is produced for a flushed load.
- Flush in WB is ignored: the write-back still occurs. Flush in IDLE has no effect.

## Timing
- Reset:
  - State goes to IDLE on the first rising edge with i_rst_n low.
  - o_mem_valid, o_wb_valid and o_fault are 0; o_wb_rd, o_wb_data and o_mem_addr are 0.
  - o_req_ready is 0 while i_rst_n is low.
- Reset mid-operation discards everything. A response that arrives after reset is ignored, because IDLE ignores i_mem_rvalid.
- Latency with zero-wait memory (i_mem_ready=1, rvalid the cycle after the handshake), request accepted in cycle T:
  - Aligned: o_mem_valid in T+1, rvalid in T+2, o_wb_valid in T+3.
  - Split: o_wb_valid in T+5.
  - Fault: o_wb_valid in T+1.
- o_wb_valid is high for exactly one cycle. o_wb_data, o_wb_rd and o_fault are registered and valid in that cycle.
- The earliest next accept is the cycle after WB, so maximum throughput is one load per 4 cycles when aligned.
- Wait states on i_mem_ready or i_mem_rvalid extend latency cycle for cycle.

## Test plan
- XLEN=32, LB at addr 0x1003, rdata 0x80FF_1234, signed → o_wb_data 0xFFFF_FF80. Unsigned LBU → 0x0000_0080. o_wb_valid in T+3.
- XLEN=32, LH at 0x2002, rdata 0x8001_5555 → 0xFFFF_8001. LHU → 0x0000_8001.
- XLEN=32, MISALIGN_EN=1, LW at 0x3003:
  - Beat 0 at 0x3000 returns 0x4433_2211; beat 1 at 0x3004 returns 0x8877_6655.
  - Expect o_wb_data 0x7766_5544 in T+5.
  - Repeat with MISALIGN_EN=0 → o_fault=1, data 0, o_wb_valid in T+1, o_mem_valid never asserted.
- XLEN=64, LD at 0x10, rdata 0x0123_4567_89AB_CDEF → same value.
  - LW signed at 0x14 → 0x0000_0000_0123_4567.
  - LW signed at 0x10 → 0xFFFF_FFFF_89AB_CDEF.
- Flush in WAIT0 with rvalid delayed 3 cycles → unit enters DRAIN and swallows the response. No o_wb_valid. o_req_ready returns the cycle after rvalid.
- i_mem_ready held low 4 cycles → o_mem_valid and o_mem_addr stable throughout.
- Assert i_rst_n low during WAIT1, then deliver a stray rvalid → no write-back, and o_req_ready=1 after reset.
